// File: rtl/aes_core_scheduler.sv
// Round-robin scheduler that time-shares one masked AES core among NUM_REQ requesters,
// with a RUN watchdog and a forced PRNG reseed after every RESEED_EVERY completed jobs.
module aes_core_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int CORE_TIMEOUT = 255,
    parameter int RESEED_EVERY = 16,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int RCW = $clog2(CORE_TIMEOUT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [IDW-1:0]     grant_id,
    output logic               core_load,
    output logic               core_rst,
    input  logic               core_done,
    output logic [NUM_REQ-1:0] resp_valid,
    input  logic [NUM_REQ-1:0] resp_ready,
    output logic               prng_reseed,
    input  logic               prng_ready,
    output logic [15:0]        jobs_done,
    output logic               timeout_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        RESP   = 3'd3,
        RESEED = 3'd4,
        ERROR  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [RCW-1:0]     run_cnt_q, run_cnt_d;
    logic [7:0]         reseed_cnt_q, reseed_cnt_d;
    logic [15:0]        jobs_q, jobs_d;
    logic               core_load_q, core_load_d;
    logic               core_rst_q, core_rst_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic               prng_reseed_q, prng_reseed_d;
    logic               timeout_err_q, timeout_err_d;

    logic               reseed_due;
    logic               win_found;
    logic [IDW-1:0]     win;
    logic [IDW:0]       idx;

    assign reseed_due = (reseed_cnt_q == 8'(RESEED_EVERY));

    // Round-robin pick: first asserted request scanning upward from rr_ptr, wrapping.
    always_comb begin
        win       = rr_ptr_q;
        win_found = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(NUM_REQ)) idx = idx - (IDW+1)'(NUM_REQ);
            if (!win_found && req_valid[idx[IDW-1:0]]) begin
                win_found = 1'b1;
                win       = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        run_cnt_d    = run_cnt_q;
        reseed_cnt_d = reseed_cnt_q;
        jobs_d       = jobs_q;
        req_ready    = '0;

        case (state_q)
            IDLE: begin
                if (reseed_due) begin
                    state_d = RESEED;
                end else if (win_found) begin
                    req_ready[win] = 1'b1;
                    grant_d        = win;
                    rr_ptr_d       = (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    state_d        = LOAD;
                end
            end
            LOAD: begin
                run_cnt_d = '0;
                state_d   = RUN;
            end
            RUN: begin
                run_cnt_d = run_cnt_q + 1'b1;
                // A done arriving on the last allowed cycle still counts as success.
                if (core_done) state_d = RESP;
                else if (run_cnt_q == RCW'(CORE_TIMEOUT - 1)) state_d = ERROR;
            end
            RESP: begin
                if (resp_ready[grant_q]) begin
                    jobs_d       = jobs_q + 16'd1;
                    reseed_cnt_d = reseed_cnt_q + 8'd1;
                    state_d      = IDLE;
                end
            end
            RESEED: begin
                if (prng_ready) begin
                    reseed_cnt_d = '0;
                    state_d      = IDLE;
                end
            end
            ERROR: state_d = ERROR;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        core_load_d   = (state_d == LOAD);
        core_rst_d    = (state_d != RUN);
        prng_reseed_d = (state_d == RESEED);
        timeout_err_d = timeout_err_q | (state_d == ERROR);
        resp_valid_d  = '0;
        if (state_d == RESP) resp_valid_d[grant_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            run_cnt_q     <= '0;
            reseed_cnt_q  <= '0;
            jobs_q        <= '0;
            core_load_q   <= 1'b0;
            core_rst_q    <= 1'b1;
            resp_valid_q  <= '0;
            prng_reseed_q <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            run_cnt_q     <= run_cnt_d;
            reseed_cnt_q  <= reseed_cnt_d;
            jobs_q        <= jobs_d;
            core_load_q   <= core_load_d;
            core_rst_q    <= core_rst_d;
            resp_valid_q  <= resp_valid_d;
            prng_reseed_q <= prng_reseed_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign grant_id    = grant_q;
    assign core_load   = core_load_q;
    assign core_rst    = core_rst_q;
    assign resp_valid  = resp_valid_q;
    assign prng_reseed = prng_reseed_q;
    assign jobs_done   = jobs_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Directed bench for aes_core_scheduler: 4 requesters, 60-cycle watchdog, reseed every 2 jobs.
module tb_aes_core_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [1:0]  grant_id;
    logic        core_load;
    logic        core_rst;
    logic        core_done;
    logic [3:0]  resp_valid;
    logic [3:0]  resp_ready;
    logic        prng_reseed;
    logic        prng_ready;
    logic [15:0] jobs_done;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int exp_jobs = 0;
    int exp_rs = 0;

    aes_core_scheduler #(.NUM_REQ(4), .CORE_TIMEOUT(60), .RESEED_EVERY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .grant_id(grant_id),
        .core_load(core_load), .core_rst(core_rst), .core_done(core_done),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .prng_reseed(prng_reseed), .prng_ready(prng_ready),
        .jobs_done(jobs_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; resp_ready = '0; core_done = 1'b0; prng_ready = 1'b0;
        cyc(); cyc();
        chk("rst_core_rst", core_rst, 1);
        chk("rst_core_load", core_load, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_prng", prng_reseed, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_jobs", jobs_done, 0);
        chk("rst_grant", grant_id, 0);
        rst = 1'b0;
        exp_jobs = 0;
        exp_rs = 0;
    endtask

    // One complete job; a due reseed (2 completed jobs) is serviced first with prng_ready late by 5 cycles.
    task automatic run_job(input logic [3:0] vld, input int w, input int lat, input int hold);
        logic [3:0] oh;
        int nlow, nrv, nbad;
        oh = 4'b0001 << w;
        if (exp_rs == 2) begin
            req_valid = vld; #1;
            chk("rs_no_accept", req_ready, 0);
            cyc();
            nbad = 0;
            for (int i = 0; i < 5; i++) begin
                if (prng_reseed !== 1'b1 || req_ready !== 4'b0) nbad++;
                cyc();
            end
            chk("rs_wait", nbad, 0);
            prng_ready = 1'b1;
            chk("rs_req_held", prng_reseed, 1);
            cyc();
            prng_ready = 1'b0;
            chk("rs_drop", prng_reseed, 0);
            exp_rs = 0;
        end
        req_valid = vld; #1;
        chk("req_ready", req_ready, oh);
        cyc();
        req_valid = vld & ~oh;
        chk("load_pulse", core_load, 1);
        chk("load_core_rst", core_rst, 1);
        chk("grant_id", grant_id, w);
        chk("load_req_ready", req_ready, 0);
        cyc();
        nlow = 0; nbad = 0;
        for (int i = 0; i < lat; i++) begin
            if (core_rst === 1'b0) nlow++;
            if (core_load !== 1'b0 || resp_valid !== 4'b0) nbad++;
            cyc();
        end
        core_done = 1'b1;
        if (core_rst === 1'b0) nlow++;
        cyc();
        core_done = 1'b0;
        chk("run_low_cycles", nlow, lat + 1);
        chk("run_glitches", nbad, 0);
        nrv = 0; nbad = 0;
        for (int i = 0; i <= hold; i++) begin
            resp_ready = (i == hold) ? oh : ~oh;
            if (resp_valid === oh) nrv++;
            if (core_rst !== 1'b1 || req_ready !== 4'b0 || jobs_done !== 16'(exp_jobs)) nbad++;
            cyc();
        end
        resp_ready = '0;
        exp_jobs++;
        exp_rs++;
        chk("resp_cycles", nrv, hold + 1);
        chk("resp_hold_bad", nbad, 0);
        chk("resp_drop", resp_valid, 0);
        chk("jobs_done", jobs_done, exp_jobs);
    endtask

    initial begin
        int nbad;
        do_reset();

        // Single request, then wrap-around pick under backpressure, then reseed.
        run_job(4'b0010, 1, 50, 0);
        run_job(4'b0001, 0, 5, 10);
        run_job(4'b1111, 1, 3, 0);

        // Fairness from a fresh rr_ptr with everyone requesting.
        do_reset();
        run_job(4'b1111, 0, 2, 0);
        run_job(4'b1111, 1, 2, 0);
        run_job(4'b1111, 2, 2, 0);
        run_job(4'b1111, 3, 2, 0);
        run_job(4'b1111, 0, 2, 0);
        run_job(4'b1111, 1, 2, 0);
        run_job(4'b1111, 2, 2, 0);
        run_job(4'b1111, 3, 2, 0);

        // Done on the last allowed RUN cycle (run_cnt == 59).
        run_job(4'b0100, 2, 59, 0);
        chk("edge_no_timeout", timeout_err, 0);

        // Reset in the middle of RUN aborts without a response.
        req_valid = 4'b1000; #1;
        chk("abort_req_ready", req_ready, 4'b1000);
        cyc();
        req_valid = '0;
        cyc(); cyc(); cyc();
        chk("abort_in_run", core_rst, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("abort_core_rst", core_rst, 1);
        chk("abort_jobs", jobs_done, 0);
        core_done = 1'b1;
        resp_ready = 4'b1111;
        nbad = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid !== 4'b0 || core_load !== 1'b0 || core_rst !== 1'b1) nbad++;
            cyc();
        end
        core_done = 1'b0;
        resp_ready = '0;
        chk("abort_quiet", nbad, 0);
        exp_jobs = 0;
        exp_rs = 0;

        // Watchdog: rr_ptr is 0 again after reset, so requester 1 wins.
        req_valid = 4'b0010; #1;
        chk("wd_req_ready", req_ready, 4'b0010);
        cyc();
        req_valid = '0;
        cyc();
        nbad = 0;
        for (int i = 0; i < 60; i++) begin
            if (core_rst !== 1'b0 || timeout_err !== 1'b0) nbad++;
            cyc();
        end
        chk("wd_run_cycles", nbad, 0);
        chk("wd_timeout_err", timeout_err, 1);
        chk("wd_core_rst", core_rst, 1);
        core_done = 1'b1; resp_ready = 4'b1111; req_valid = 4'b1111; prng_ready = 1'b1;
        nbad = 0;
        for (int i = 0; i < 6; i++) begin
            if (timeout_err !== 1'b1 || core_rst !== 1'b1 || req_ready !== 4'b0 ||
                resp_valid !== 4'b0 || core_load !== 1'b0 || prng_reseed !== 1'b0) nbad++;
            cyc();
        end
        chk("wd_sticky", nbad, 0);
        do_reset();
        chk("post_wd_req_ready", req_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
